// File: rtl/uart_mmio_bridge_pkg.sv
// Shared types and register map for the memory-mapped UART bridge.
package uart_mmio_bridge_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_WAIT_START,
    TX_WAIT_DONE
  } bridge_tx_state_t;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;

  // Word index of each register, as decoded from bus_addr[3:2].
  localparam logic [1:0] IDX_TXDATA = REG_TXDATA[3:2];
  localparam logic [1:0] IDX_RXDATA = REG_RXDATA[3:2];
  localparam logic [1:0] IDX_STATUS = REG_STATUS[3:2];
  localparam logic [1:0] IDX_CTRL   = REG_CTRL[3:2];

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_TX_ACTIVE    = 4;
  localparam int ST_RX_OVERRUN   = 5;
  localparam int ST_PARITY_ERR   = 6;
  localparam int ST_TX_OVERFLOW  = 7;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

endpackage

// File: rtl/uart_mmio_bridge_fifo.sv
// Byte FIFO with first-word fall-through head; a pop frees a slot for a same-cycle push.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_mmio_bridge.sv
// MMIO front end for a full-duplex UART: RX/TX byte FIFOs, status/ctrl registers, TX launch sequencer.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_we,
  input  logic                  bus_re,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_parity_error,
  output logic                  rx_clr,
  input  logic                  tx_busy,
  output logic                  tx_send,
  output logic [7:0]            tx_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  logic          rx_pop, tx_push, ctrl_we, clr_sticky, rx_flush, tx_flush;
  logic          rx_capture, tx_pop;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]    rx_dout, tx_dout;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_overrun, parity_err, tx_overflow;
  logic          set_overrun, set_parity, set_overflow;
  logic [TW-1:0] wait_cnt;
  logic          start_timeout;
  bridge_tx_state_t state, next_state;
  logic          unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[DATA_WIDTH-1:3]};

  assign rx_pop     = bus_re && (bus_addr[3:2] == IDX_RXDATA);
  assign tx_push    = bus_we && (bus_addr[3:2] == IDX_TXDATA);
  assign ctrl_we    = bus_we && (bus_addr[3:2] == IDX_CTRL);
  assign clr_sticky = ctrl_we && bus_wdata[0];
  assign rx_flush   = ctrl_we && bus_wdata[1];
  assign tx_flush   = ctrl_we && bus_wdata[2];

  // The UART flag is still high on the cycle our clear lands; skip it so one byte is captured once.
  assign rx_capture   = rx_valid && !rx_clr;
  assign set_overrun  = rx_capture && rx_full && !rx_pop && !rx_flush;
  assign set_parity   = rx_capture && rx_parity_error;
  assign set_overflow = tx_push && tx_full && !tx_pop;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_capture), .din(rx_data), .pop(rx_pop), .flush(rx_flush),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(bus_wdata[7:0]), .pop(tx_pop), .flush(tx_flush),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overrun  <= 1'b0;
      parity_err  <= 1'b0;
      tx_overflow <= 1'b0;
      rx_clr      <= 1'b0;
    end else begin
      rx_overrun  <= set_overrun  || (rx_overrun  && !clr_sticky);
      parity_err  <= set_parity   || (parity_err  && !clr_sticky);
      tx_overflow <= set_overflow || (tx_overflow && !clr_sticky);
      rx_clr      <= rx_capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= next_state;
  end

  assign start_timeout = (wait_cnt == TW'(START_TIMEOUT - 1));

  always_comb begin
    next_state = state;
    case (state)
      TX_IDLE:       if (!tx_empty && !tx_busy) next_state = TX_LAUNCH;
      TX_LAUNCH:     next_state = TX_WAIT_START;
      TX_WAIT_START: if (tx_busy) next_state = TX_WAIT_DONE;
                     else if (start_timeout) next_state = TX_IDLE;
      TX_WAIT_DONE:  if (!tx_busy) next_state = TX_IDLE;
      default:       next_state = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = (state == TX_IDLE) && !tx_empty && !tx_busy;
    tx_send = (state == TX_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (rst || state != TX_WAIT_START) wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         tx_data <= 8'h00;
    else if (tx_pop) tx_data <= tx_dout;
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr[3:2])
      IDX_RXDATA: bus_rdata[7:0] = rx_empty ? 8'h00 : rx_dout;
      IDX_STATUS: begin
        bus_rdata[ST_RX_NOT_EMPTY] = !rx_empty;
        bus_rdata[ST_RX_FULL]      = rx_full;
        bus_rdata[ST_TX_EMPTY]     = tx_empty;
        bus_rdata[ST_TX_FULL]      = tx_full;
        bus_rdata[ST_TX_ACTIVE]    = (state != TX_IDLE);
        bus_rdata[ST_RX_OVERRUN]   = rx_overrun;
        bus_rdata[ST_PARITY_ERR]   = parity_err;
        bus_rdata[ST_TX_OVERFLOW]  = tx_overflow;
        bus_rdata[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
        bus_rdata[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
      end
      default: bus_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Bench for uart_mmio_bridge: queue-based model checked every cycle plus directed literal checks.
module tb_uart_mmio_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we, bus_re;
  logic [31:0] bus_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_parity_error;
  logic        rx_clr;
  logic        tx_busy;
  logic        tx_send;
  logic [7:0]  tx_data;

  uart_mmio_bridge #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_re(bus_re), .bus_rdata(bus_rdata), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_error(rx_parity_error), .rx_clr(rx_clr), .tx_busy(tx_busy),
    .tx_send(tx_send), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred where none was expected", nm);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       m_clr, m_ovr, m_par, m_ovf;
  logic       cap, ctrl, clr, s_ovr, s_par, s_ovf;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      rxq.delete(); txq.delete();
      m_clr = 0; m_ovr = 0; m_par = 0; m_ovf = 0;
    end else begin
      cap   = rx_valid && !m_clr;
      ctrl  = bus_we && bus_addr[3:2] == 2'd3;
      clr   = ctrl && bus_wdata[0];
      s_ovr = 0; s_ovf = 0;
      s_par = cap && rx_parity_error;
      if (ctrl && bus_wdata[1]) rxq.delete();
      else begin
        if (bus_re && bus_addr[3:2] == 2'd1 && rxq.size() > 0) void'(rxq.pop_front());
        if (cap) begin
          if (rxq.size() < 8) rxq.push_back(rx_data);
          else s_ovr = 1;
        end
      end
      if (bus_we && bus_addr[3:2] == 2'd0) begin
        if (txq.size() < 8) txq.push_back(bus_wdata[7:0]);
        else s_ovf = 1;
      end
      m_ovr = s_ovr || (m_ovr && !clr);
      m_par = s_par || (m_par && !clr);
      m_ovf = s_ovf || (m_ovf && !clr);
      m_clr = cap;
    end
  end

  // ---------------- UART transmitter stand-in ----------------
  int   busy_mode = 0;  // 0: busy 20 cycles after each launch, 1: stuck high, 2: stuck low
  int   bcnt = 0;
  logic snd;
  always @(posedge clk) begin
    snd = tx_send;
    #1;
    case (busy_mode)
      0: begin
        if (snd) bcnt = 20;
        tx_busy = (bcnt > 0);
        if (bcnt > 0) bcnt--;
      end
      1: tx_busy = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  end

  // ---------------- compare process ----------------
  logic [7:0]  sent_q[$];
  int          send_cyc[$];
  logic        prev_send = 1'b0;
  int          busy_viol = 0;
  int          n_clr = 0;
  logic        aa_seen = 1'b0;
  logic [31:0] exp_st;

  always @(negedge clk) begin
    check("rx_clr", {31'b0, rx_clr}, {31'b0, m_clr});
    if (tx_send) begin
      if (txq.size() == 0) fail("tx_send_spurious");
      else begin
        check("tx_data", {24'b0, tx_data}, {24'b0, txq[0]});
        void'(txq.pop_front());
      end
      if (prev_send) fail("tx_send_width");
      if (tx_busy) busy_viol++;
      if (tx_data == 8'hAA) aa_seen = 1'b1;
      sent_q.push_back(tx_data);
      send_cyc.push_back(cyc);
    end
    if (rx_clr) n_clr++;
    prev_send = tx_send;
    case (bus_addr[3:2])
      2'd1: if (bus_re) check("rxdata", bus_rdata, rxq.size() > 0 ? {24'b0, rxq[0]} : 32'h0);
      2'd2: begin
        exp_st = '0;
        exp_st[0] = rxq.size() != 0;
        exp_st[1] = rxq.size() == 8;
        exp_st[5] = m_ovr;
        exp_st[6] = m_par;
        exp_st[7] = m_ovf;
        exp_st[15:8] = 8'(rxq.size());
        check("status_model", bus_rdata & 32'hFF00_FFE3, exp_st);
      end
      default: check("wo_read_zero", bus_rdata, 32'h0);
    endcase
  end

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(posedge clk); #1;
    bus_we = 1'b0; bus_addr = 4'h8;
  endtask

  task automatic rd(output logic [31:0] v);
    bus_addr = 4'h4; bus_re = 1'b1;
    @(negedge clk); #1;
    v = bus_rdata;
    @(posedge clk); #1;
    bus_re = 1'b0; bus_addr = 4'h8;
  endtask

  task automatic status(output logic [31:0] s);
    @(negedge clk); #1;
    s = bus_rdata;
    @(posedge clk); #1;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic p);
    bit seen = 0;
    rx_data = d; rx_parity_error = p; rx_valid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (rx_clr) seen = 1;
    end
    if (!seen) fail("rx_clr_timeout");
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_parity_error = 1'b0;
  endtask

  task automatic wait_tx_idle(input int bound);
    logic [31:0] s;
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      status(s);
      if (s[2] && !s[4]) done = 1;
    end
    if (!done) fail("tx_idle_timeout");
    check("tx_active_end", {31'b0, s[4]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] s, v;

  initial begin
    rst = 1'b1; bus_addr = 4'h8; bus_wdata = '0; bus_we = 0; bus_re = 0;
    rx_valid = 0; rx_data = 0; rx_parity_error = 0; tx_busy = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk); #1;
    check("reset_status", bus_rdata, 32'h0000_0004);
    check("reset_tx_send", {31'b0, tx_send}, 32'h0);
    check("reset_rx_clr", {31'b0, rx_clr}, 32'h0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h0);
    @(posedge clk); #1;

    // three back-to-back TX writes
    sent_q.delete(); busy_viol = 0;
    wr(4'h0, 32'h01); wr(4'h0, 32'h02); wr(4'h0, 32'h03);
    wait_tx_idle(200);
    check("t2_sends", sent_q.size(), 3);
    check("t2_byte0", {24'b0, sent_q[0]}, 32'h01);
    check("t2_byte1", {24'b0, sent_q[1]}, 32'h02);
    check("t2_byte2", {24'b0, sent_q[2]}, 32'h03);
    check("t2_busy_launch", busy_viol, 0);

    // RX overrun: 9 bytes into an 8-deep FIFO
    n_clr = 0;
    for (int b = 0; b < 9; b++) rx_byte(8'h10 + 8'(b), 1'b0);
    status(s);
    check("t3_rx_count", {24'b0, s[15:8]}, 32'h8);
    check("t3_overrun", {31'b0, s[5]}, 32'h1);
    check("t3_rx_full", {31'b0, s[1]}, 32'h1);
    check("t3_clr_pulses", n_clr, 9);
    for (int i = 0; i < 8; i++) begin
      rd(v);
      check("t3_rd", v, 32'h10 + 32'(i));
    end
    rd(v);
    check("t3_rd_empty", v, 32'h0);

    // parity flag and sticky clear
    wr(4'hC, 32'h1);
    rx_byte(8'h55, 1'b1);
    status(s);
    check("t4_parity_set", {31'b0, s[6]}, 32'h1);
    check("t4_rx_count", {24'b0, s[15:8]}, 32'h1);
    wr(4'hC, 32'h1);
    status(s);
    check("t4_parity_clr", {31'b0, s[6]}, 32'h0);
    check("t4_overrun_clr", {31'b0, s[5]}, 32'h0);
    rd(v);
    check("t4_rd", v, 32'h55);

    // TX overflow while the UART is busy
    busy_mode = 1; cycles(2);
    sent_q.delete(); aa_seen = 0;
    for (int i = 0; i < 8; i++) wr(4'h0, 32'hA0 + 32'(i));
    wr(4'h0, 32'hAA);
    status(s);
    check("t5_tx_count", {24'b0, s[23:16]}, 32'h8);
    check("t5_overflow", {31'b0, s[7]}, 32'h1);
    check("t5_tx_full", {31'b0, s[3]}, 32'h1);
    busy_mode = 0;
    wait_tx_idle(600);
    check("t5_sends", sent_q.size(), 8);
    check("t5_last", {24'b0, sent_q[7]}, 32'hA7);
    check("t5_no_aa", {31'b0, aa_seen}, 32'h0);
    wr(4'hC, 32'h1);

    // start timeout with tx_busy stuck low
    busy_mode = 2; cycles(2);
    sent_q.delete(); send_cyc.delete();
    wr(4'h0, 32'h5A); wr(4'h0, 32'h5B);
    wait_tx_idle(200);
    check("t6_sends", sent_q.size(), 2);
    check("t6_second", {24'b0, sent_q[1]}, 32'h5B);
    check("t6_spacing", send_cyc[1] - send_cyc[0], 18);

    // reset in the middle of a transfer
    busy_mode = 0; cycles(2);
    sent_q.delete();
    rx_byte(8'h77, 1'b0);
    wr(4'h0, 32'h61); wr(4'h0, 32'h62);
    for (int i = 0; i < 20 && sent_q.size() == 0; i++) cycles(1);
    if (sent_q.size() == 0) fail("t7_first_launch_timeout");
    cycles(3);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("t7_status", bus_rdata, 32'h0000_0004);
    check("t7_tx_send", {31'b0, tx_send}, 32'h0);
    check("t7_rx_clr", {31'b0, rx_clr}, 32'h0);
    check("t7_tx_data", {24'b0, tx_data}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    cycles(60);
    check("t7_no_relaunch", sent_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
